// File: rtl/itlb_ctrl.sv
// ITLB control stage: tag/valid storage, lookup match, page-table-walk handshake
// and victim fill into the external entry array.
`ifndef MXLEN
`define MXLEN 64
`endif

module itlb_ctrl #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned VPN_W   = 27,
  parameter int unsigned PTE_W   = `MXLEN
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               lookup_valid_i,
  input  logic [VPN_W-1:0]   lookup_vpn_i,
  output logic               lookup_ready_o,
  output logic               resp_valid_o,
  output logic               resp_hit_o,
  output logic               resp_fault_o,
  output logic [PTE_W-1:0]   resp_pte_o,
  output logic               ptw_req_valid_o,
  input  logic               ptw_req_ready_i,
  output logic [VPN_W-1:0]   ptw_req_vpn_o,
  input  logic               ptw_resp_valid_i,
  input  logic [PTE_W-1:0]   ptw_resp_pte_i,
  input  logic               ptw_resp_fault_i,
  output logic [ENTRIES-1:0] entry_rd_en_o,
  output logic [ENTRIES-1:0] entry_wr_en_o,
  output logic [PTE_W-1:0]   entry_wr_pte_o,
  input  logic [PTE_W-1:0]   entry_rd_pte_i
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {IDLE, RESP, REQ, WAIT, FILL} state_e;

  state_e             state_q, state_d, st_c;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [VPN_W-1:0]   tag_q [ENTRIES];
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic [ENTRIES-1:0] rd_sel_q, rd_sel_d;
  logic [PTE_W-1:0]   pte_q, pte_d;
  logic               fault_q, fault_d;
  logic               walked_q, walked_d;
  logic               flush_pend_q, flush_pend_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [ENTRIES-1:0] hit_vec_c;
  logic [ENTRIES-1:0] victim_oh_c;
  logic [IDX_W-1:0]   victim_idx_c;
  logic               fill_we_c;

  // While reset is held, outputs look like IDLE regardless of the stale state.
  assign st_c = rstn_i ? state_q : IDLE;

  // Tag match; a flush in the acceptance cycle forces a miss.
  always_comb begin
    hit_vec_c = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      hit_vec_c[i] = valid_q[i] && (tag_q[i] == lookup_vpn_i) && !flush_i;
    end
  end

  // Victim: lowest-index invalid entry, else the round-robin pointer.
  always_comb begin
    victim_idx_c = ptr_q;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) victim_idx_c = IDX_W'(i);
    end
    victim_oh_c = ENTRIES'(1) << victim_idx_c;
  end

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    vpn_d           = vpn_q;
    rd_sel_d        = rd_sel_q;
    pte_d           = pte_q;
    fault_d         = fault_q;
    walked_d        = walked_q;
    flush_pend_d    = flush_pend_q;
    ptr_d           = ptr_q;
    fill_we_c       = 1'b0;
    lookup_ready_o  = 1'b0;
    resp_valid_o    = 1'b0;
    resp_hit_o      = 1'b0;
    resp_fault_o    = 1'b0;
    resp_pte_o      = '0;
    ptw_req_valid_o = 1'b0;
    ptw_req_vpn_o   = '0;
    entry_rd_en_o   = '0;
    entry_wr_en_o   = '0;
    entry_wr_pte_o  = '0;

    case (st_c)
      IDLE: begin
        lookup_ready_o = 1'b1;
        if (lookup_valid_i) begin
          vpn_d        = lookup_vpn_i;
          rd_sel_d     = hit_vec_c;
          fault_d      = 1'b0;
          flush_pend_d = 1'b0;
          if (|hit_vec_c) begin
            walked_d = 1'b0;
            state_d  = RESP;
          end else begin
            walked_d = 1'b1;
            state_d  = REQ;
          end
        end
      end
      RESP: begin
        entry_rd_en_o = rd_sel_q;
        resp_valid_o  = 1'b1;
        resp_hit_o    = !walked_q;
        resp_fault_o  = fault_q;
        // A suppressed fill leaves nothing to read back; return the captured PTE.
        if (fault_q)        resp_pte_o = '0;
        else if (|rd_sel_q) resp_pte_o = entry_rd_pte_i;
        else                resp_pte_o = pte_q;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      REQ: begin
        ptw_req_valid_o = 1'b1;
        ptw_req_vpn_o   = vpn_q;
        if (ptw_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (ptw_resp_valid_i) begin
          if (ptw_resp_fault_i) begin
            fault_d  = 1'b1;
            pte_d    = '0;
            rd_sel_d = '0;
            state_d  = RESP;
          end else begin
            pte_d   = ptw_resp_pte_i;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        fill_we_c = !flush_pend_q && !flush_i;
        if (fill_we_c) begin
          entry_wr_en_o  = victim_oh_c;
          entry_wr_pte_o = pte_q;
          valid_d        = valid_q | victim_oh_c;
          ptr_d          = ptr_q + IDX_W'(1);
          rd_sel_d       = victim_oh_c;
        end else begin
          rd_sel_d = '0;
        end
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      valid_d = '0;
      if (st_c == REQ || st_c == WAIT || st_c == FILL) flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      vpn_q        <= '0;
      rd_sel_q     <= '0;
      pte_q        <= '0;
      fault_q      <= 1'b0;
      walked_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      vpn_q        <= vpn_d;
      rd_sel_q     <= rd_sel_d;
      pte_q        <= pte_d;
      fault_q      <= fault_d;
      walked_q     <= walked_d;
      flush_pend_q <= flush_pend_d;
      ptr_q        <= ptr_d;
    end
  end

  // Tags are qualified by valid bits, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (fill_we_c) tag_q[victim_idx_c] <= vpn_q;
  end

endmodule

// File: tb/tb_itlb_ctrl.sv
// Bench for itlb_ctrl: directed vector table, hand-written corner sequences and
// random transactions checked against a set-of-translations reference model.
module tb_itlb_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        lookup_valid;
  logic [26:0] lookup_vpn;
  logic        lookup_ready;
  logic        resp_valid, resp_hit, resp_fault;
  logic [63:0] resp_pte;
  logic        ptw_req_valid, ptw_req_ready;
  logic [26:0] ptw_req_vpn;
  logic        ptw_resp_valid, ptw_resp_fault;
  logic [63:0] ptw_resp_pte;
  logic [7:0]  rd_en, wr_en;
  logic [63:0] wr_pte, rd_pte;

  always #5 clk = ~clk;

  itlb_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .lookup_valid_i(lookup_valid), .lookup_vpn_i(lookup_vpn), .lookup_ready_o(lookup_ready),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_fault_o(resp_fault), .resp_pte_o(resp_pte),
    .ptw_req_valid_o(ptw_req_valid), .ptw_req_ready_i(ptw_req_ready), .ptw_req_vpn_o(ptw_req_vpn),
    .ptw_resp_valid_i(ptw_resp_valid), .ptw_resp_pte_i(ptw_resp_pte), .ptw_resp_fault_i(ptw_resp_fault),
    .entry_rd_en_o(rd_en), .entry_wr_en_o(wr_en), .entry_wr_pte_o(wr_pte), .entry_rd_pte_i(rd_pte)
  );

  // Entry storage as seen by the controller.
  logic [63:0] ent [8];
  always @(posedge clk) for (int i = 0; i < 8; i++) if (wr_en[i]) ent[i] <= wr_pte;
  always_comb begin
    rd_pte = '0;
    for (int i = 0; i < 8; i++) if (rd_en[i]) rd_pte = rd_pte | ent[i];
  end

  // Reference model: set of cached translations plus replacement pointer.
  bit          mv [8];
  logic [26:0] mt [8];
  logic [63:0] mp [8];
  int          mptr;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [26:0] vpn;
    logic [63:0] pte;
    bit          fault;
    int          rdy_dly;
    bit          flush_acc;
    bit          flush_wait;
    bit          exp_hit;
  } tv_t;

  tv_t tv [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) mv[i] = 0;
    mptr = 0;
  endfunction

  function automatic int m_find(input logic [26:0] vpn);
    for (int i = 0; i < 8; i++) if (mv[i] && mt[i] == vpn) return i;
    return -1;
  endfunction

  function automatic int m_victim();
    for (int i = 0; i < 8; i++) if (!mv[i]) return i;
    return mptr;
  endfunction

  function automatic logic [63:0] oh(input int i);
    logic [63:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // One full lookup transaction; walker behaviour is taken from the record.
  task automatic txn(input tv_t t, output bit hit_o, output logic [7:0] wr_o);
    int idx, v;
    idx = t.flush_acc ? -1 : m_find(t.vpn);
    if (t.flush_acc) for (int i = 0; i < 8; i++) mv[i] = 0;
    wr_o = '0;
    lookup_valid = 1'b1; lookup_vpn = t.vpn; flush = t.flush_acc;
    @(negedge clk); chk("accept_ready", lookup_ready, 1);
    tick();
    lookup_valid = 1'b0; flush = 1'b0; lookup_vpn = 27'($urandom);
    if (idx >= 0) begin
      @(negedge clk);
      chk("hit_valid", resp_valid, 1);
      chk("hit_flag", resp_hit, 1);
      chk("hit_rd_en", rd_en, oh(idx));
      chk("hit_pte", resp_pte, mp[idx]);
      chk("hit_no_walk", ptw_req_valid, 0);
      hit_o = resp_hit;
      tick();
    end else begin
      for (int c = 0; c <= t.rdy_dly; c++) begin
        ptw_req_ready = (c == t.rdy_dly);
        @(negedge clk);
        chk("req_valid", ptw_req_valid, 1);
        chk("req_vpn", ptw_req_vpn, t.vpn);
        chk("req_no_resp", resp_valid, 0);
        tick();
      end
      ptw_req_ready = 1'b0; flush = t.flush_wait;
      @(negedge clk); chk("wait_quiet", {ptw_req_valid, resp_valid, wr_en}, 0);
      tick();
      flush = 1'b0;
      if (t.flush_wait) for (int i = 0; i < 8; i++) mv[i] = 0;
      ptw_resp_valid = 1'b1; ptw_resp_pte = t.pte; ptw_resp_fault = t.fault;
      tick();
      ptw_resp_valid = 1'b0; ptw_resp_fault = 1'b0;
      v = -1;
      if (!t.fault) begin
        if (!t.flush_wait) v = m_victim();
        @(negedge clk);
        chk("fill_wr_en", wr_en, oh(v));
        if (v >= 0) chk("fill_pte", wr_pte, t.pte);
        chk("fill_no_resp", resp_valid, 0);
        wr_o = wr_en;
        tick();
        if (v >= 0) begin
          mv[v] = 1; mt[v] = t.vpn; mp[v] = t.pte; mptr = (mptr + 1) % 8;
        end
      end
      @(negedge clk);
      chk("walk_resp_valid", resp_valid, 1);
      chk("walk_resp_hit", resp_hit, 0);
      chk("walk_resp_fault", resp_fault, t.fault);
      chk("walk_resp_pte", resp_pte, t.fault ? 64'h0 : t.pte);
      chk("walk_resp_no_wr", wr_en, 0);
      chk("walk_resp_rd_en", rd_en, oh(v));
      hit_o = resp_hit;
      tick();
    end
    @(negedge clk); chk("back_idle", {lookup_ready, resp_valid, ptw_req_valid}, 3'b100);
    tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          h;
    logic [7:0]  w;
    tv_t         t;

    rstn = 1'b0; flush = 0; lookup_valid = 0; lookup_vpn = '0;
    ptw_req_ready = 0; ptw_resp_valid = 0; ptw_resp_pte = '0; ptw_resp_fault = 0;
    m_reset();

    tv[0] = '{27'h123, 64'h0000_0000_2000_00CF, 0, 0, 0, 0, 0};
    tv[1] = '{27'h123, 64'h0,                   0, 0, 0, 0, 1};
    tv[2] = '{27'h200, 64'hDEAD_BEEF_0000_0001, 1, 5, 0, 0, 0};
    tv[3] = '{27'h200, 64'h0000_0000_0000_0055, 0, 2, 0, 0, 0};
    tv[4] = '{27'h300, 64'h0000_0000_0000_0077, 0, 0, 0, 1, 0};
    tv[5] = '{27'h300, 64'h0000_0000_0000_0078, 0, 1, 0, 0, 0};
    tv[6] = '{27'h300, 64'h0,                   0, 0, 0, 0, 1};
    tv[7] = '{27'h300, 64'h0000_0000_0000_0079, 0, 0, 1, 0, 0};
    tv[8] = '{27'h123, 64'h0000_0000_0000_0099, 0, 0, 0, 0, 0};

    // Reset values, during and right after reset.
    @(negedge clk);
    chk("in_reset", {lookup_ready, resp_valid, resp_hit, resp_fault, ptw_req_valid, rd_en, wr_en}, {1'b1, 20'h0});
    chk("in_reset_buses", {resp_pte, ptw_req_vpn, wr_pte}, 0);
    tick(); tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset", {lookup_ready, resp_valid, resp_hit, resp_fault, ptw_req_valid, rd_en, wr_en}, {1'b1, 20'h0});
    tick();

    for (int i = 0; i < 9; i++) begin
      txn(tv[i], h, w);
      chk($sformatf("tbl%0d_hit", i), h, tv[i].exp_hit);
      if (i == 0) chk("first_fill_entry0", w, 8'h01);
    end

    // Nine distinct fills into eight entries: the ninth wraps to entry 0.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      t = '{27'h400 + 27'(i), 64'h1000 + 64'(i), 0, 0, 0, 0, 0};
      txn(t, h, w);
      if (i == 8) chk("wrap_fill_entry0", w, 8'h01);
    end
    t = '{27'h401, 64'h0, 0, 0, 0, 0, 1};
    txn(t, h, w); chk("wrap_second_hits", h, 1);
    t = '{27'h400, 64'h2000, 0, 0, 0, 0, 0};
    txn(t, h, w); chk("wrap_first_misses", h, 0);

    // Reset while a walk is outstanding; the late walk response is dropped.
    lookup_valid = 1'b1; lookup_vpn = 27'h401; tick();
    lookup_valid = 1'b0; ptw_req_ready = 1'b1; tick();
    ptw_req_ready = 1'b0;
    @(negedge clk); chk("midwalk_waiting", {ptw_req_valid, resp_valid}, 0);
    tick();
    rstn = 1'b0;
    @(negedge clk); chk("midwalk_in_reset", {lookup_ready, resp_valid, ptw_req_valid}, 3'b100);
    tick();
    rstn = 1'b1; m_reset();
    @(negedge clk); chk("midwalk_idle", {lookup_ready, resp_valid, ptw_req_valid, wr_en}, {3'b100, 8'h0});
    ptw_resp_valid = 1'b1; ptw_resp_pte = 64'hBAD; tick();
    ptw_resp_valid = 1'b0;
    @(negedge clk); chk("late_resp_ignored", {lookup_ready, resp_valid, wr_en, rd_en}, {2'b10, 16'h0});
    tick();
    t = '{27'h401, 64'h3000, 0, 0, 0, 0, 0};
    txn(t, h, w); chk("midwalk_valid_cleared", h, 0);

    // Random traffic over a small VPN pool so hits, evictions and flushes mix.
    for (int n = 0; n < 300; n++) begin
      t.vpn        = 27'($urandom_range(0, 11));
      t.pte        = {$urandom, $urandom};
      t.fault      = ($urandom_range(0, 7) == 0);
      t.rdy_dly    = $urandom_range(0, 3);
      t.flush_acc  = ($urandom_range(0, 15) == 0);
      t.flush_wait = ($urandom_range(0, 15) == 0);
      t.exp_hit    = !t.flush_acc && (m_find(t.vpn) >= 0);
      txn(t, h, w);
      chk("rand_hit", h, t.exp_hit);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
